// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - ALSU command format, opcodes and command validity helper
// Contents:
//   alsu_cmd_t  16-bit packed ALSU command, opcode in the top bits
//   OP_*        ALSU opcode values
//   ALSU_NOP    all-zero command (OR of A=0, B=0, result 0)
//   is_invalid  flags opcodes 6/7 and reduction requests on non-logic opcodes
package alsu_pkg;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
  } alsu_cmd_t;

  localparam logic [2:0] OP_OR    = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  localparam alsu_cmd_t ALSU_NOP = '0;

  // Reduction is only meaningful for OR/XOR; opcodes above ROT do not exist.
  function automatic logic is_invalid(alsu_cmd_t c);
    return (c.opcode > OP_ROT) ||
           ((c.red_op_a | c.red_op_b) && (c.opcode >= OP_ADD));
  endfunction

endpackage

// File: rtl/alsu_rr_arbiter.sv
// rtl/alsu_rr_arbiter.sv - combinational round-robin grant with lock override
// Ports:
//   valid       in   NUM_REQ  request lines
//   ptr         in   IDW      highest-priority requester when unlocked
//   lock_en     in   1        grant restricted to lock_owner
//   lock_owner  in   IDW      requester holding the lock
//   grant       out  NUM_REQ  one-hot grant (all zero when nothing granted)
//   grant_id    out  IDW      index of the granted requester
module alsu_rr_arbiter
  import alsu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  input  logic               lock_en,
  input  logic [IDW-1:0]     lock_owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    if (lock_en) begin
      // Locked: the owner alone may be granted, others stall even if it is idle.
      grant_id          = lock_owner;
      grant[lock_owner] = valid[lock_owner];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = IDW'((int'(ptr) + k) % NUM_REQ);
        if (!found && valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/alsu_arbiter.sv
// rtl/alsu_arbiter.sv - shares one ALSU between NUM_REQ requesters, routes results back
// Optional feature: ALSU_ARB_INVALID_CHECK_EN (invalid commands become NOP with rsp_err=1)
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/ready/cmd/lock   per-requester command port (16-bit alsu_cmd_t each)
//   rsp_valid                  per-requester one-cycle result strobe
//   rsp_data, rsp_err          shared result and invalid-command flag
//   A, B, opcode, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B
//                              registered ALSU input pins
//   alsu_out                   ALSU result
module alsu_arbiter
  import alsu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 2,
  parameter int OUT_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]    req_lock,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [OUT_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [2:0]            A,
  output logic [2:0]            B,
  output logic [2:0]            opcode,
  output logic                  cin,
  output logic                  serial_in,
  output logic                  direction,
  output logic                  red_op_A,
  output logic                  red_op_B,
  output logic                  bypass_A,
  output logic                  bypass_B,
  input  logic [OUT_W-1:0]      alsu_out
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]     ptr;
  logic               lock_en;
  logic [IDW-1:0]     lock_owner;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               accept;
  alsu_cmd_t          sel_cmd;
  logic               sel_lock;
  logic               cmd_err;
  alsu_cmd_t          pin_q;

  logic               pipe_vld [LATENCY];
  logic [IDW-1:0]     pipe_id  [LATENCY];
  logic               pipe_err [LATENCY];
  logic               rsp_vld_q;
  logic [IDW-1:0]     rsp_id_q;
  logic               rsp_err_q;

  alsu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .valid      (req_valid),
    .ptr        (ptr),
    .lock_en    (lock_en),
    .lock_owner (lock_owner),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Grant only ever covers valid requesters, so any grant bit is an accept.
  assign accept    = |grant;
  assign req_ready = rst ? '0 : grant;

  always_comb begin
    sel_cmd  = ALSU_NOP;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_cmd  = alsu_cmd_t'(req_cmd[i*16 +: 16]);
        sel_lock = req_lock[i];
      end
    end
  end

`ifdef ALSU_ARB_INVALID_CHECK_EN
  assign cmd_err = is_invalid(sel_cmd);
`else
  assign cmd_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q      <= ALSU_NOP;
      ptr        <= '0;
      lock_en    <= 1'b0;
      lock_owner <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_id[i]  <= '0;
        pipe_err[i] <= 1'b0;
      end
    end else begin
      // Idle cycles and rejected commands drive NOP so the ALSU output settles to 0.
      pin_q <= (accept && !cmd_err) ? sel_cmd : ALSU_NOP;

      if (accept) begin
        ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        if (sel_lock) begin
          lock_en    <= 1'b1;
          lock_owner <= grant_id;
        end else if (lock_en && (lock_owner == grant_id)) begin
          lock_en <= 1'b0;
        end
      end

      pipe_vld[0] <= accept;
      pipe_id[0]  <= grant_id;
      pipe_err[0] <= accept & cmd_err;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
        pipe_err[i] <= pipe_err[i-1];
      end

      // Extra register stage lines the strobe up with the edge the ALSU updates out.
      rsp_vld_q <= pipe_vld[LATENCY-1];
      rsp_id_q  <= pipe_id[LATENCY-1];
      rsp_err_q <= pipe_vld[LATENCY-1] & pipe_err[LATENCY-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_vld_q && (rsp_id_q == IDW'(i))) rsp_valid[i] = 1'b1;
    end
  end

  assign rsp_data = alsu_out;
  assign rsp_err  = rsp_err_q;

  assign opcode    = pin_q.opcode;
  assign A         = pin_q.a;
  assign B         = pin_q.b;
  assign cin       = pin_q.cin;
  assign serial_in = pin_q.serial_in;
  assign direction = pin_q.direction;
  assign red_op_A  = pin_q.red_op_a;
  assign red_op_B  = pin_q.red_op_b;
  assign bypass_A  = pin_q.bypass_a;
  assign bypass_B  = pin_q.bypass_b;

endmodule
